// File: rtl/aes_pkg.sv
// Shared AES-128 encryption definitions: FSM encoding, round constants and
// the linear round steps (xtime, MixColumns on one column, ShiftRows).
package aes_pkg;

  localparam int NUM_ROUNDS_128 = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Rcon indexed by round 1..10; any other round returns zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are packed with row 0 in the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  // Byte i of a block lives at bits [127-8i -: 8]; out byte 4c+r = in byte 4((c+r)%4)+r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) (as x^254) followed
// by the affine transform with constant 0x63.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  import aes_pkg::*;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Addition chain to x^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = gf_mul(x, x);
    t = gf_mul(t, x);
    t = gf_mul(t, t);
    t = gf_mul(t, x);
    t = gf_mul(t, t);
    t = gf_mul(t, x);
    t = gf_mul(t, t);
    t = gf_mul(t, x);
    t = gf_mul(t, t);
    t = gf_mul(t, x);
    t = gf_mul(t, t);
    t = gf_mul(t, x);
    t = gf_mul(t, t);
    return t;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key
// expansion, valid/ready on both sides, a single block in flight.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ciphertext
);

  if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_rounds
    $error("aes_encrypt_iter supports only NUM_ROUNDS = 10");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready and out_valid come from the FSM state register only.
  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] ct_q, ct_d;

  logic [127:0] sub_state;
  logic [31:0]  rot_word, sub_word;
  logic [127:0] next_key, shifted, mixed, round_out;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .in_byte  (blk_q[127-8*i -: 8]),
      .out_byte (sub_state[127-8*i -: 8])
    );
  end

  assign rot_word = {rkey_q[23:0], rkey_q[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_word[31-8*j -: 8]),
      .out_byte (sub_word[31-8*j -: 8])
    );
  end

  always_comb begin
    next_key[127:96] = rkey_q[127:96] ^ sub_word ^ {rcon(round_q), 24'h000000};
    next_key[95:64]  = rkey_q[95:64] ^ next_key[127:96];
    next_key[63:32]  = rkey_q[63:32] ^ next_key[95:64];
    next_key[31:0]   = rkey_q[31:0]  ^ next_key[63:32];
    shifted = shift_rows(sub_state);
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
    // The final round skips MixColumns.
    round_out = ((round_q == 4'd10) ? shifted : mixed) ^ next_key;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      blk_q   <= '0;
      rkey_q  <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      rkey_q  <= rkey_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    blk_d   = blk_q;
    rkey_d  = rkey_q;
    ct_d    = ct_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          fsm_d   = RUN;
          round_d = 4'd1;
          blk_d   = plaintext ^ key;
          rkey_d  = key;
        end
      end
      RUN: begin
        if (round_q == 4'd0 || round_q > 4'd10) begin
          fsm_d   = IDLE;
          round_d = 4'd0;
        end else begin
          blk_d   = round_out;
          rkey_d  = next_key;
          round_d = round_q + 4'd1;
          if (round_q == 4'd10) begin
            fsm_d   = DONE;
            round_d = 4'd0;
            ct_d    = round_out;
          end
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    in_ready   = (fsm_q == IDLE);
    out_valid  = (fsm_q == DONE);
    ciphertext = ct_q;
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using FIPS-197 vectors, backpressure,
// input scrambling during RUN and a mid-operation reset.
module tb_aes_encrypt_iter;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] plaintext;
  logic [0:127] key;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] ciphertext;

  int checks = 0;
  int errors = 0;
  int cyc;
  int spurious;
  logic [127:0] r1_state;
  logic [127:0] held_ct;

  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_R0   = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C_R1   = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt_iter #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one block at a negedge; returns just after the accept edge.
  task automatic accept(input logic [127:0] pt, input logic [127:0] k);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1'b1);
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after accept until out_valid is seen (bounded).
  task automatic wait_done(input bit scramble);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) r1_state = dut.blk_q;
      if (scramble) begin
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        key       = {$urandom, $urandom, $urandom, $urandom};
      end
    end while (!out_valid && cyc < 40);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_handshake", out_valid, 1'b0);
    chk("in_ready_after_handshake", in_ready, 1'b1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input bit scramble);
    accept(pt, k);
    wait_done(scramble);
    chk({tag, "_latency"}, cyc, 10);
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_ct"}, ciphertext, exp);
    handshake();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    #12;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_ct", ciphertext, 128'h0);
    chk("reset_fsm", dut.fsm_q, IDLE);
    chk("reset_round", dut.round_q, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 C.1 with round-0 and round-1 state checks.
    accept(C_PT, C_KEY);
    chk("c1_round0_state", dut.blk_q, C_R0);
    chk("c1_in_ready_run", in_ready, 1'b0);
    wait_done(1'b0);
    chk("c1_round1_state", r1_state, C_R1);
    chk("c1_latency", cyc, 10);
    chk("c1_ct", ciphertext, C_CT);
    handshake();

    run_block("fips_b", B_PT, B_KEY, B_CT, 1'b0);
    run_block("zero", 128'h0, 128'h0, Z_CT, 1'b0);

    // Backpressure with a second block queued during DONE.
    accept(C_PT, C_KEY);
    wait_done(1'b0);
    chk("bp_ct", ciphertext, C_CT);
    held_ct   = ciphertext;
    in_valid  = 1'b1;
    plaintext = B_PT;
    key       = B_KEY;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ct_stable", ciphertext, held_ct);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_out_valid_held", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_out_valid_drop", out_valid, 1'b0);
    chk("bp_idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(1'b0);
    chk("queued_latency", cyc, 10);
    chk("queued_ct", ciphertext, B_CT);
    handshake();

    // Inputs wiggle every cycle during RUN; the sampled values must win.
    run_block("scramble", B_PT, B_KEY, B_CT, 1'b1);

    // Reset at round 5 discards the block.
    accept(C_PT, C_KEY);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_round_is_5", dut.round_q, 4'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", out_valid, 1'b0);
    chk("mid_reset_in_ready", in_ready, 1'b1);
    chk("mid_reset_ct", ciphertext, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    chk("no_spurious_out_valid", spurious, 0);
    run_block("after_reset", C_PT, C_KEY, C_CT, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
